// File: rtl/blood_sprite_engine.sv
// blood_sprite_engine
// Address generator and compositor for the blood-splatter sprite ROMs.
// A hit arms the engine, play starts on the next frame_tick, and the
// animation steps one ROM frame every TICKS_PER_FRAME frame_ticks.
// The overlay output is aligned to the one-cycle ROM read latency
// (2 clk total from x/y to blood_on/blood_rgb).
// Optional feature macro: BLOOD_RETRIGGER_EN (hit while busy restarts
// the animation at the new anchor).
module blood_sprite_engine #(
  parameter int          SPRITE_DIM      = 64,
  parameter int          FRAMES          = 32,
  parameter int          TICKS_PER_FRAME = 4,
  parameter logic [11:0] KEY_COLOR       = 12'h000,
  localparam int         AW              = $clog2(SPRITE_DIM),
  localparam int         FW              = $clog2(FRAMES)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          video_on,
  input  logic          frame_tick,
  input  logic          hit,
  input  logic [9:0]    anchor_x,
  input  logic [9:0]    anchor_y,
  output logic [AW-1:0] rom_row,
  output logic [AW-1:0] rom_col,
  output logic [FW-1:0] rom_frame,
  input  logic [11:0]   rom_color,
  output logic          blood_on,
  output logic [11:0]   blood_rgb,
  output logic          busy
);

  localparam int TW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;

  typedef enum logic [1:0] {IDLE, ARM, PLAY} state_t;

  state_t        state_q, state_d;
  logic [9:0]    ax_q, ax_d;
  logic [9:0]    ay_q, ay_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          d_q;
  logic          in_box;
  logic [AW-1:0] row_off;
  logic [AW-1:0] col_off;
  logic          opaque;

  // State, anchor and animation counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ax_q    <= '0;
      ay_q    <= '0;
      tick_q  <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      tick_q  <= tick_d;
      frame_q <= frame_d;
    end
  end

  // Next-state logic; frame only advances on frame_tick so it is stable per video frame
  always_comb begin
    state_d = state_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    tick_d  = tick_q;
    frame_d = frame_q;
    case (state_q)
      IDLE: begin
        if (hit) begin
          ax_d    = anchor_x;
          ay_d    = anchor_y;
          state_d = ARM;
        end
      end
      ARM: begin
        if (frame_tick) begin
          state_d = PLAY;
          frame_d = '0;
          tick_d  = '0;
        end
      end
      PLAY: begin
        if (frame_tick) begin
          if (tick_q == TW'(TICKS_PER_FRAME - 1)) begin
            tick_d = '0;
            if (frame_q == FW'(FRAMES - 1)) begin
              frame_d = '0;
              state_d = IDLE;
            end else begin
              frame_d = frame_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef BLOOD_RETRIGGER_EN
    if (hit && (state_q != IDLE)) begin
      ax_d    = anchor_x;
      ay_d    = anchor_y;
      frame_d = '0;
      tick_d  = '0;
      state_d = ARM;
    end
`endif
  end

  // Sprite window with 11-bit sums so anchors near the right/bottom edge clip instead of wrapping
  always_comb begin
    in_box = (x >= ax_q) && ({1'b0, x} < ({1'b0, ax_q} + 11'(SPRITE_DIM))) &&
             (y >= ay_q) && ({1'b0, y} < ({1'b0, ay_q} + 11'(SPRITE_DIM)));
    row_off = y[AW-1:0] - ay_q[AW-1:0];
    col_off = x[AW-1:0] - ax_q[AW-1:0];
    rom_row = in_box ? row_off : '0;
    rom_col = in_box ? col_off : '0;
    opaque  = (rom_color != KEY_COLOR);
  end

  // Overlay pipeline: qualify at address time, composite when the ROM colour returns
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_q       <= 1'b0;
      blood_on  <= 1'b0;
      blood_rgb <= '0;
    end else begin
      d_q       <= in_box && video_on && (state_q == PLAY);
      blood_on  <= d_q && opaque;
      blood_rgb <= (d_q && opaque) ? rom_color : 12'h000;
    end
  end

  assign rom_frame = frame_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_blood_sprite_engine.sv
// Directed self-checking bench for blood_sprite_engine.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_blood_sprite_engine;

  logic        clk;
  logic        reset_n;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        video_on;
  logic        frame_tick;
  logic        hit;
  logic [9:0]  anchor_x;
  logic [9:0]  anchor_y;
  logic [5:0]  rom_row;
  logic [5:0]  rom_col;
  logic [4:0]  rom_frame;
  logic [11:0] rom_color;
  logic        blood_on;
  logic [11:0] blood_rgb;
  logic        busy;

  int checks;
  int failures;

  blood_sprite_engine dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .x          (x),
    .y          (y),
    .video_on   (video_on),
    .frame_tick (frame_tick),
    .hit        (hit),
    .anchor_x   (anchor_x),
    .anchor_y   (anchor_y),
    .rom_row    (rom_row),
    .rom_col    (rom_col),
    .rom_frame  (rom_frame),
    .rom_color  (rom_color),
    .blood_on   (blood_on),
    .blood_rgb  (blood_rgb),
    .busy       (busy)
  );

  // Free-running pixel clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset_n    = 1'b1;
    x          = '0;
    y          = '0;
    video_on   = 1'b0;
    frame_tick = 1'b0;
    hit        = 1'b0;
    anchor_x   = '0;
    anchor_y   = '0;
    rom_color  = '0;

    // Reset state
    #1 reset_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame", 32'(rom_frame), 32'd0);
    check("rst_on", 32'(blood_on), 32'd0);
    check("rst_rgb", 32'(blood_rgb), 32'd0);
    #10 reset_n = 1'b1;
    step();

    // Hit and frame_tick together in IDLE: ARM only, no blood drawn yet
    anchor_x   = 10'd100;
    anchor_y   = 10'd50;
    hit        = 1'b1;
    frame_tick = 1'b1;
    step();
    hit        = 1'b0;
    frame_tick = 1'b0;
    check("arm_busy", 32'(busy), 32'd1);
    x = 10'd100; y = 10'd50; video_on = 1'b1; rom_color = 12'hD00;
    step();
    step();
    check("arm_no_blood", 32'(blood_on), 32'd0);
    video_on = 1'b0;

    // Enter PLAY
    tick(1);
    check("play_frame0", 32'(rom_frame), 32'd0);
    check("play_busy", 32'(busy), 32'd1);

    // Right-most sprite column, 2-cycle latency
    x = 10'd163; y = 10'd50; video_on = 1'b1; rom_color = 12'h000;
    #1;
    check("addr_col63", 32'(rom_col), 32'd63);
    check("addr_row0", 32'(rom_row), 32'd0);
    step();
    rom_color = 12'hE00;
    check("lat_not_yet", 32'(blood_on), 32'd0);
    step();
    check("lat_on", 32'(blood_on), 32'd1);
    check("lat_rgb", 32'(blood_rgb), 32'hE00);

    // One past the right edge
    x = 10'd164;
    #1;
    check("out_col", 32'(rom_col), 32'd0);
    check("out_row", 32'(rom_row), 32'd0);
    step();
    step();
    check("out_on", 32'(blood_on), 32'd0);
    check("out_rgb", 32'(blood_rgb), 32'd0);

    // Transparency key
    x = 10'd110; y = 10'd60;
    #1;
    check("mid_col", 32'(rom_col), 32'd10);
    check("mid_row", 32'(rom_row), 32'd10);
    step();
    rom_color = 12'h000;
    step();
    check("key_on", 32'(blood_on), 32'd0);
    check("key_rgb", 32'(blood_rgb), 32'd0);
    rom_color = 12'hD00;
    step();
    check("opaque_on", 32'(blood_on), 32'd1);
    check("opaque_rgb", 32'(blood_rgb), 32'hD00);

    // Blanked when video_on is low
    video_on = 1'b0;
    step();
    step();
    check("vid_off_on", 32'(blood_on), 32'd0);

    // Frame stepping: 4 ticks per frame
    tick(3);
    check("frame_hold", 32'(rom_frame), 32'd0);
    tick(1);
    check("frame1", 32'(rom_frame), 32'd1);
    tick(36);
    check("frame10", 32'(rom_frame), 32'd10);

    // Hit while playing
    anchor_x = 10'd200;
    anchor_y = 10'd300;
    hit = 1'b1;
    step();
    hit = 1'b0;
`ifdef BLOOD_RETRIGGER_EN
    check("retrig_frame", 32'(rom_frame), 32'd0);
    check("retrig_busy", 32'(busy), 32'd1);
    x = 10'd205; y = 10'd305;
    #1;
    check("retrig_col", 32'(rom_col), 32'd5);
    check("retrig_row", 32'(rom_row), 32'd5);
    tick(1);
    tick(4);
    check("retrig_frame1", 32'(rom_frame), 32'd1);
    tick(123);
`else
    check("ignore_frame", 32'(rom_frame), 32'd10);
    x = 10'd105; y = 10'd55;
    #1;
    check("ignore_col", 32'(rom_col), 32'd5);
    check("ignore_row", 32'(rom_row), 32'd5);
    tick(4);
    check("ignore_frame11", 32'(rom_frame), 32'd11);
    tick(83);
`endif
    check("last_frame", 32'(rom_frame), 32'd31);
    check("last_busy", 32'(busy), 32'd1);
    tick(1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_frame", 32'(rom_frame), 32'd0);

    // Right-edge clip: anchor at column 1000
    anchor_x = 10'd1000;
    anchor_y = 10'd0;
    hit = 1'b1;
    step();
    hit = 1'b0;
    tick(1);
    x = 10'd1023; y = 10'd0; video_on = 1'b1; rom_color = 12'hA50;
    #1;
    check("clip_col23", 32'(rom_col), 32'd23);
    step();
    step();
    check("clip_on", 32'(blood_on), 32'd1);
    check("clip_rgb", 32'(blood_rgb), 32'hA50);
    x = 10'd20;
    #1;
    check("alias_col", 32'(rom_col), 32'd0);
    step();
    step();
    check("alias_on", 32'(blood_on), 32'd0);

    // Async reset mid-PLAY at frame 7
    x = 10'd1023;
    tick(28);
    check("pre_rst_frame", 32'(rom_frame), 32'd7);
    check("pre_rst_on", 32'(blood_on), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_frame", 32'(rom_frame), 32'd0);
    check("async_on", 32'(blood_on), 32'd0);
    check("async_rgb", 32'(blood_rgb), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blood_sprite_engine.md
Name: blood_sprite_engine

Overview:
Address generator and compositor that sits directly upstream of the blood-splatter sprite ROMs (64x64, 12-bit colour, one-cycle registered-address latency). On a hit pulse it latches an on-screen anchor and plays a multi-frame splatter animation. It converts VGA pixel coordinates into ROM row/col/frame addresses and consumes the returned colour. It outputs a latency-aligned overlay pixel with colour-key transparency for the top-level RGB mux.

Parameters:
SPRITE_DIM, 64, sprite width and height in pixels (power of two; row/col width = log2).
FRAMES, 32, number of animation frames; rom_frame counts 0..FRAMES-1.
TICKS_PER_FRAME, 4, frame_tick pulses per animation frame (>=1).
KEY_COLOR, 12'h000, ROM colour treated as transparent.

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
x  in  10  current pixel column
y  in  10  current pixel row
video_on  in  1  visible-area flag, same cycle as x/y
frame_tick  in  1  one-cycle pulse at start of vertical blank
hit  in  1  one-cycle trigger pulse
anchor_x  in  10  sprite top-left column, sampled on accepted hit
anchor_y  in  10  sprite top-left row, sampled on accepted hit
rom_row  out  6  ROM row address (combinational from x/y)
rom_col  out  6  ROM column address (combinational from x/y)
rom_frame  out  5  ROM/frame select
rom_color  in  12  ROM colour_data, valid one cycle after rom_row/rom_col
blood_on  out  1  overlay pixel valid (registered-aligned)
blood_rgb  out  12  overlay colour; 0 when blood_on=0
busy  out  1  animation armed or playing

Behaviour:
- Reset, async on reset_n low: state=IDLE; anchors=0; tick_cnt=0; rom_frame=0; busy=0; blood_on=0; blood_rgb=0; all delay registers=0.
- FSM states: IDLE, ARM, PLAY.
  - IDLE + hit: latch anchor_x/anchor_y, go to ARM.
  - ARM: wait for frame_tick, then go to PLAY with rom_frame=0 and tick_cnt=0. This keeps the animation starting on a frame boundary, so there is no tearing.
  - PLAY: on each frame_tick, tick_cnt increments.
    - When tick_cnt==TICKS_PER_FRAME-1: tick_cnt clears and rom_frame increments.
    - When rom_frame==FRAMES-1 at that rollover: go to IDLE and set rom_frame=0.
- busy=1 in ARM and PLAY.
- rom_frame changes only on frame_tick, so it is stable for the whole visible frame.
- Hit while ARM/PLAY is ignored; the anchor is not re-sampled (see the optional feature).
- hit and frame_tick in the same cycle while IDLE: enter ARM only. The tick is not consumed, so play starts on the next tick.
- Window: in_box = (x>=ax) && ({1'b0,x} < ax+SPRITE_DIM) && (y>=ay) && ({1'b0,y} < ay+SPRITE_DIM).
  - Sums are 11-bit, so an anchor near 1023 does not wrap; the part of the sprite past 1023 is clipped.
- rom_row = (y-ay)[5:0] and rom_col = (x-ax)[5:0]. Both are 0 when not in_box.
- Pipeline: one stage. Register d = in_box & video_on & (state==PLAY), sampled with the current address.
  - Next cycle: blood_on = d & (rom_color != KEY_COLOR).
  - blood_rgb = blood_on ? rom_color : 0.
  - Both outputs are registered.
  - Total latency from x/y to blood_on/blood_rgb is 2 clk. The top level delays its background path to match.
- The state tested by d is the state at address time. A transition to IDLE mid-line therefore blanks the very next pixel.

Optional Feature:
BLOOD_RETRIGGER_EN
- Defined: hit in ARM or PLAY re-latches the anchor, sets rom_frame=0 and tick_cnt=0, and enters ARM.
- Hit and end-of-animation in the same cycle: retrigger wins and the state goes to ARM.
- Undefined: hits outside IDLE are ignored.

Test Plan:
- Reset: assert reset_n=0 mid-PLAY with rom_frame=7 -> state IDLE, rom_frame=0, blood_on=0, blood_rgb=0 immediately, without waiting for a clock edge.
- Play timing: hit with anchor (100,50), then 1 frame_tick to enter PLAY, then 4 further ticks -> rom_frame=1. After 128 ticks total in PLAY -> IDLE, busy=0.
- Addressing/latency: PLAY, x=163, y=50, video_on=1 -> rom_col=63, rom_row=0 in the same cycle. rom_color=12'hE00 is returned one cycle later, and blood_on=1 with blood_rgb=12'hE00 two cycles after x/y. At x=164 -> in_box=0, rom_row/rom_col=0, and blood_on=0 two cycles later.
- Transparency: in-box pixel with rom_color=12'h000 -> blood_on=0, blood_rgb=0. With rom_color=12'hD00 -> blood_on=1, blood_rgb=12'hD00.
- Edge clip: anchor_x=1000, x=1023 -> rom_col=23, sprite visible. Sprite pixels past column 1023 are clipped, and x=0..39 does not alias into the sprite.
- Retrigger: hit during PLAY at rom_frame=10.
  - Without BLOOD_RETRIGGER_EN: rom_frame continues to 11 and the anchor is unchanged.
  - With BLOOD_RETRIGGER_EN: state goes to ARM, rom_frame=0, and the new anchor is latched.
